// File: rtl/nano_lsu.sv
// nano_lsu: single-outstanding load/store unit between the execute stage and the data bus.
// Optional macro NANO_LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module nano_lsu #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] d_addr_o,
    output logic [31:0]       d_data_o,
    output logic [3:0]        d_be_o,
    output logic              d_rd_o,
    output logic              d_wr_o,
    input  logic [31:0]       d_data_i,
    input  logic              d_ack_i,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a request is taken on a rising edge where req_valid_i and req_ready_o are both 1;
    // the response is the single cycle where rsp_valid_o is 1 (no back-pressure on responses).

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_t state;
    state_t state_nxt;

    logic                we_q;
    logic                uns_q;
    logic [1:0]          size_q;
    logic [1:0]          lane_q;
    logic [ADDR_W-3:0]   word_addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic [CNT_W-1:0]    cnt;

    logic                req_fire;
    logic                req_illegal;
    logic                req_misalign;
    logic                req_reject;
    logic [1:0]          req_lane;
    logic [3:0]          req_be;
    logic [31:0]         req_bus_data;
    logic                timeout_hit;
    logic [31:0]         lane_data;
    logic [31:0]         load_ext;

    assign req_fire    = req_valid_i && (state == ST_IDLE);
    assign req_illegal = (req_size_i == 2'b11);

`ifdef NANO_LSU_MISALIGN_TRAP_EN
    assign req_misalign = ((req_size_i == 2'b01) && req_addr_i[0]) ||
                          ((req_size_i == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    assign req_misalign = 1'b0;
`endif

    assign req_reject = req_illegal || req_misalign;

    // Effective lane: offset bits below the access size are dropped when not trapping.
    always_comb begin
        req_lane     = 2'b00;
        req_be       = 4'b0000;
        req_bus_data = 32'h0;
        case (req_size_i)
            2'b00: begin
                req_lane     = req_addr_i[1:0];
                req_be       = 4'b0001 << req_addr_i[1:0];
                req_bus_data = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_lane     = {req_addr_i[1], 1'b0};
                req_be       = req_addr_i[1] ? 4'b1100 : 4'b0011;
                req_bus_data = {2{req_wdata_i[15:0]}};
            end
            2'b10: begin
                req_lane     = 2'b00;
                req_be       = 4'b1111;
                req_bus_data = req_wdata_i;
            end
            default: begin
                req_lane     = 2'b00;
                req_be       = 4'b0000;
                req_bus_data = 32'h0;
            end
        endcase
    end

    assign timeout_hit = TIMEOUT_EN && (cnt == CNT_LAST);

    assign lane_data = d_data_i >> {lane_q, 3'b000};

    always_comb begin
        load_ext = 32'h0;
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_ext = {{16{~uns_q & lane_data[15]}}, lane_data[15:0]};
            default: load_ext = lane_data;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack on the timeout edge still completes normally.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_fire) begin
                    state_nxt = req_reject ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                if (d_ack_i || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are gated by state so an asynchronous reset drops the strobes at once.
    always_comb begin
        req_ready_o = (state == ST_IDLE);
        rsp_valid_o = (state == ST_RESP);
        rsp_rdata_o = (state == ST_RESP) ? rdata_q : 32'h0;
        rsp_err_o   = (state == ST_RESP) && err_q;
        d_rd_o      = (state == ST_BUS) && !we_q;
        d_wr_o      = (state == ST_BUS) && we_q;
        d_addr_o    = (state == ST_BUS) ? {word_addr_q, 2'b00} : '0;
        d_be_o      = (state == ST_BUS) ? be_q : 4'b0000;
        d_data_o    = (state == ST_BUS) ? wdata_q : 32'h0;
        dbg_state_o = state;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            word_addr_q <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            cnt         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (req_fire) begin
                        we_q        <= req_we_i;
                        uns_q       <= req_unsigned_i;
                        size_q      <= req_size_i;
                        lane_q      <= req_lane;
                        word_addr_q <= req_addr_i[ADDR_W-1:2];
                        be_q        <= req_be;
                        wdata_q     <= req_bus_data;
                        rdata_q     <= 32'h0;
                        err_q       <= req_reject;
                    end
                end
                ST_BUS: begin
                    if (d_ack_i) begin
                        rdata_q <= we_q ? 32'h0 : load_ext;
                        err_q   <= 1'b0;
                        cnt     <= '0;
                    end else if (timeout_hit) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nano_lsu.sv
// Bench for nano_lsu: directed vector table, reset-abort sequence, and random traffic vs. a reference model.
module tb_nano_lsu;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = 2'b00;
    logic        req_unsigned_i = 1'b0;
    logic [31:0] req_addr_i = 32'h0;
    logic [31:0] req_wdata_i = 32'h0;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [31:0] d_addr_o;
    logic [31:0] d_data_o;
    logic [3:0]  d_be_o;
    logic        d_rd_o;
    logic        d_wr_o;
    logic [31:0] d_data_i = 32'h0;
    logic        d_ack_i = 1'b0;
    logic [1:0]  dbg_state_o;

    int n_total = 0;
    int n_pass  = 0;

    nano_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TIMEOUT), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .d_addr_o(d_addr_o), .d_data_o(d_data_o), .d_be_o(d_be_o),
        .d_rd_o(d_rd_o), .d_wr_o(d_wr_o), .d_data_i(d_data_i), .d_ack_i(d_ack_i),
        .dbg_state_o(dbg_state_o)
    );

    // Clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        int          ack_wait;
        logic [3:0]  be;
        logic [31:0] bdata;
        logic [31:0] rdata;
        logic        err;
        int          cycles;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] bus_rdata, input int ack_wait,
                                input logic [3:0] be, input logic [31:0] bdata,
                                input logic [31:0] rdata, input logic err, input int cycles);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.bus_rdata = bus_rdata; v.ack_wait = ack_wait; v.be = be; v.bdata = bdata;
        v.rdata = rdata; v.err = err; v.cycles = cycles;
        return v;
    endfunction

    // Reference model: byte counts, offsets and masks straight from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          nbytes;
        int          off;
        int          eff;
        bit          trap;
        logic [31:0] mask;
        logic [31:0] raw;
        r = v;
`ifdef NANO_LSU_MISALIGN_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
        r.be = 4'h0; r.bdata = 32'h0; r.rdata = 32'h0; r.err = 1'b0; r.cycles = 0;
        if (v.size == 2'd3) begin
            r.err = 1'b1;
            return r;
        end
        nbytes = 1 << v.size;
        off    = int'(v.addr[1:0]);
        if (trap && (off % nbytes) != 0) begin
            r.err = 1'b1;
            return r;
        end
        eff  = off - (off % nbytes);
        r.be = 4'(((1 << nbytes) - 1) << eff);
        for (int i = 0; i < 4; i++) r.bdata[8*i +: 8] = v.wdata[8*(i % nbytes) +: 8];
        if (v.ack_wait >= TIMEOUT) begin
            r.cycles = TIMEOUT;
            r.err    = 1'b1;
            return r;
        end
        r.cycles = v.ack_wait + 1;
        if (!v.we) begin
            mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*nbytes)) - 32'h1);
            raw  = (v.bus_rdata >> (8*eff)) & mask;
            if (!v.uns && raw[8*nbytes-1]) raw = raw | ~mask;
            r.rdata = raw;
        end
        return r;
    endfunction

    // Driver + bus responder for one transaction, checking every phase.
    task automatic run_vec(input vec_t v, input string tag);
        int          k;
        int          strobes;
        bit          bus_bad;
        bit          done;
        logic [31:0] exp_addr;
        exp_addr = v.addr & 32'hFFFF_FFFC;
        check({tag, ".ready_idle"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = v.we; req_size_i = v.size; req_unsigned_i = v.uns;
        req_addr_i = v.addr; req_wdata_i = v.wdata;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0; req_addr_i = $urandom; req_wdata_i = $urandom;
        req_we_i = ~v.we; req_size_i = 2'($urandom_range(0, 3));
        k = 0; strobes = 0; bus_bad = 1'b0; done = 1'b0;
        while (!done && k < 64) begin
            if ((d_rd_o || d_wr_o) && !rsp_valid_o) begin
                strobes++;
                if (d_rd_o != !v.we || d_wr_o != v.we || d_addr_o != exp_addr ||
                    d_be_o != v.be || (v.we && d_data_o != v.bdata)) bus_bad = 1'b1;
                d_ack_i  = (k == v.ack_wait);
                d_data_i = (k == v.ack_wait) ? v.bus_rdata : $urandom;
                @(posedge clk_i); #1;
                d_ack_i = 1'b0;
                k++;
            end else begin
                done = 1'b1;
            end
        end
        check({tag, ".strobe_cycles"}, 32'(strobes), 32'(v.cycles));
        check({tag, ".bus_fields"}, 32'(bus_bad), 32'd0);
        check({tag, ".rsp_valid"}, 32'(rsp_valid_o), 32'd1);
        check({tag, ".ready_resp"}, 32'(req_ready_o), 32'd0);
        check({tag, ".rdata"}, rsp_rdata_o, v.rdata);
        check({tag, ".err"}, 32'(rsp_err_o), 32'(v.err));
        @(posedge clk_i); #1;
        check({tag, ".rsp_one_cycle"}, 32'(rsp_valid_o), 32'd0);
        check({tag, ".ready_after"}, 32'(req_ready_o), 32'd1);
    endtask

    vec_t tbl[$];
    vec_t rv;

    initial begin
        // Directed table: expectations written out by hand from the access rules.
        tbl.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0, 32'h8765_4321, 3, 4'hF, 32'h0, 32'h8765_4321, 0, 4));
        tbl.push_back(mk(0, 2'd0, 0, 32'h13, 32'h0, 32'h8012_3456, 0, 4'h8, 32'h0, 32'hFFFF_FF80, 0, 1));
        tbl.push_back(mk(0, 2'd0, 1, 32'h13, 32'h0, 32'h8012_3456, 0, 4'h8, 32'h0, 32'h0000_0080, 0, 1));
        tbl.push_back(mk(1, 2'd1, 0, 32'h22, 32'h1234_ABCD, 32'hDEAD_BEEF, 1, 4'hC, 32'hABCD_ABCD, 32'h0, 0, 2));
        tbl.push_back(mk(0, 2'd2, 0, 32'h40, 32'h0, 32'h1111_2222, 100, 4'hF, 32'h0, 32'h0, 1, 16));
        tbl.push_back(mk(0, 2'd2, 0, 32'h44, 32'h0, 32'h3333_4444, 15, 4'hF, 32'h0, 32'h3333_4444, 0, 16));
        tbl.push_back(mk(0, 2'd3, 0, 32'h48, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        tbl.push_back(mk(1, 2'd0, 0, 32'h01, 32'h0000_00A5, 32'h0, 2, 4'h2, 32'hA5A5_A5A5, 32'h0, 0, 3));
        tbl.push_back(mk(0, 2'd1, 1, 32'h02, 32'h0, 32'hBEEF_1234, 0, 4'hC, 32'h0, 32'h0000_BEEF, 0, 1));
        tbl.push_back(mk(0, 2'd1, 0, 32'h02, 32'h0, 32'hBEEF_1234, 0, 4'hC, 32'h0, 32'hFFFF_BEEF, 0, 1));
        tbl.push_back(mk(1, 2'd2, 0, 32'h7C, 32'hCAFE_F00D, 32'h0, 0, 4'hF, 32'hCAFE_F00D, 32'h0, 0, 1));
`ifdef NANO_LSU_MISALIGN_TRAP_EN
        tbl.push_back(mk(0, 2'd2, 0, 32'h05, 32'h0, 32'h5555_6666, 0, 4'h0, 32'h0, 32'h0, 1, 0));
        tbl.push_back(mk(0, 2'd1, 0, 32'h03, 32'h0, 32'h5555_6666, 0, 4'h0, 32'h0, 32'h0, 1, 0));
`else
        tbl.push_back(mk(0, 2'd2, 0, 32'h05, 32'h0, 32'h5555_6666, 0, 4'hF, 32'h0, 32'h5555_6666, 0, 1));
        tbl.push_back(mk(0, 2'd1, 0, 32'h03, 32'h0, 32'h8555_6666, 0, 4'hC, 32'h0, 32'hFFFF_8555, 0, 1));
`endif

        // Reset state
        #2;
        check("reset.ready", 32'(req_ready_o), 32'd1);
        check("reset.outputs", {rsp_valid_o, rsp_err_o, d_rd_o, d_wr_o, d_be_o}, 32'd0);
        check("reset.buses", rsp_rdata_o | d_addr_o | d_data_o, 32'd0);
        #20 rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted mid-BUS aborts with no response
        req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'd2; req_addr_i = 32'h30;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        check("abort.rd_before", 32'(d_rd_o), 32'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check("abort.rd_dropped", 32'(d_rd_o), 32'd0);
        check("abort.ready", 32'(req_ready_o), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk_i); #1;
            check($sformatf("abort.no_rsp%0d", c), 32'(rsp_valid_o), 32'd0);
        end
        #3 rst_n_i = 1'b1;
        // Ack while idle is ignored
        d_ack_i = 1'b1;
        @(posedge clk_i); #1;
        d_ack_i = 1'b0;
        check("idle_ack.no_rsp", 32'(rsp_valid_o), 32'd0);
        check("idle_ack.ready", 32'(req_ready_o), 32'd1);
        run_vec(tbl[0], "after_abort");

        // Random traffic against the model
        for (int n = 0; n < 150; n++) begin
            rv.we        = 1'($urandom);
            rv.size      = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rv.uns       = 1'($urandom);
            rv.addr      = $urandom;
            rv.wdata     = $urandom;
            rv.bus_rdata = $urandom;
            rv.ack_wait  = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 4);
            run_vec(model(rv), $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
